fx2_tx_sched: RTL

- Controller and arbiter for the FX2 slave-FIFO write port in the ifclk domain.
- Shares the 16-bit FX2 bus between two sources:
  - the capture word stream, which is the read side of the clock-crossing FIFO;
  - a status/marker message source.
- Tracks words per USB packet and issues PKTEND on idle timeout or an explicit flush, so partial packets reach the host.

---
 rtl/fx2_pkg.sv | 20 ++
 rtl/fx2_pkt_timer.sv | 77 +++++++
 rtl/fx2_tx_sched.sv | 122 ++++++++++++
 3 files changed

// File: rtl/fx2_pkg.sv
// +--------------------------------------------------------------------+
// | fx2_pkg: shared state encoding and defaults for the FX2 write path |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package fx2_pkg;

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_STAT = 2'd1,
        S_END  = 2'd2
    } fx2_state_e;

    localparam int FX2_PKT_WORDS_DEFAULT    = 256;
    localparam int FX2_IDLE_TIMEOUT_DEFAULT = 4096;

endpackage

`default_nettype wire

// File: rtl/fx2_pkt_timer.sv
// +--------------------------------------------------------------------+
// | fx2_pkt_timer: packet word counter, idle timer and end-pending     |
// | flag. Macro FX2_ZLP_EN lets a flush of an empty packet request a   |
// | zero-length packet.                                                |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module fx2_pkt_timer
    import fx2_pkg::*;
#(
    parameter int PKT_WORDS    = FX2_PKT_WORDS_DEFAULT,
    parameter int IDLE_TIMEOUT = FX2_IDLE_TIMEOUT_DEFAULT
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         wr_i,
    input  logic                         clr_i,
    input  logic                         flush_i,
    output logic [$clog2(PKT_WORDS)-1:0] words_o,
    output logic                         end_pending_o,
    output logic                         end_pending_d_o
);

    localparam int WW = $clog2(PKT_WORDS);
    localparam int IW = $clog2(IDLE_TIMEOUT);
    localparam logic [WW-1:0] c_words_last = WW'(PKT_WORDS - 1);
    localparam logic [IW-1:0] c_idle_last  = IW'(IDLE_TIMEOUT - 1);

    logic [WW-1:0] words_q, words_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          pend_q, pend_d;
    logic          wrap, idle_run, timeout, flush_hit;

    always_comb begin
        wrap    = wr_i && (words_q == c_words_last);
        words_d = words_q;
        if (clr_i) begin
            words_d = '0;
        end else if (wr_i) begin
            words_d = wrap ? '0 : words_q + 1'b1;
        end
        idle_run = !wr_i && (words_q != '0) && !pend_q;
        idle_d   = idle_run ? idle_q + 1'b1 : '0;
        timeout  = idle_run && (idle_d == c_idle_last);
`ifdef FX2_ZLP_EN
        flush_hit = flush_i;
`else
        flush_hit = flush_i && (words_d != '0);
`endif
        // A wrap means the FX2 already committed the packet, so any end request is moot.
        if (clr_i || wrap) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q || flush_hit || timeout;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            words_q <= '0;
            idle_q  <= '0;
            pend_q  <= 1'b0;
        end else begin
            words_q <= words_d;
            idle_q  <= idle_d;
            pend_q  <= pend_d;
        end
    end

    assign words_o         = words_q;
    assign end_pending_o   = pend_q;
    assign end_pending_d_o = pend_d;

endmodule

`default_nettype wire

// File: rtl/fx2_tx_sched.sv
// +--------------------------------------------------------------------+
// | fx2_tx_sched: FX2 slave-FIFO write arbiter for capture and status  |
// | words with PKTEND on flush/idle. Optional macro: FX2_ZLP_EN.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module fx2_tx_sched
    import fx2_pkg::*;
#(
    parameter int W            = 16,
    parameter int PKT_WORDS    = FX2_PKT_WORDS_DEFAULT,
    parameter int IDLE_TIMEOUT = FX2_IDLE_TIMEOUT_DEFAULT
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         enable_i,
    input  logic                         flush_i,
    input  logic [W-1:0]                 cap_data_i,
    input  logic                         cap_valid_i,
    output logic                         cap_ack_o,
    input  logic [W-1:0]                 stat_data_i,
    input  logic                         stat_valid_i,
    input  logic                         stat_last_i,
    output logic                         stat_ack_o,
    input  logic                         if_ready_i,
    output logic                         slwr_o,
    output logic                         pktend_o,
    output logic [W-1:0]                 fd_o,
    output logic [$clog2(PKT_WORDS)-1:0] words_o,
    output logic                         busy_o
);

    fx2_state_e   state_q, state_d;
    logic [W-1:0] fd_q, fd_d, sel_data;
    logic         sel_stat, sel_cap, wr, wr_out, clr, pend_q, pend_d;

    always_comb begin : select
        sel_stat = 1'b0;
        sel_cap  = 1'b0;
        case (state_q)
            S_RUN: begin
                if (!pend_q) begin
                    if (stat_valid_i) begin
                        sel_stat = 1'b1;
                    end else if (enable_i && cap_valid_i) begin
                        sel_cap = 1'b1;
                    end
                end
            end
            S_STAT:  sel_stat = 1'b1;
            default: ;
        endcase
        wr       = if_ready_i && ((sel_stat && stat_valid_i) || sel_cap);
        sel_data = sel_stat ? stat_data_i : cap_data_i;
        clr      = (state_q == S_END) && if_ready_i;
        fd_d     = wr ? sel_data : fd_q;
    end

    fx2_pkt_timer #(
        .PKT_WORDS    (PKT_WORDS),
        .IDLE_TIMEOUT (IDLE_TIMEOUT)
    ) u_timer (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .wr_i            (wr),
        .clr_i           (clr),
        .flush_i         (flush_i),
        .words_o         (words_o),
        .end_pending_o   (pend_q),
        .end_pending_d_o (pend_d)
    );

    // A pending end never breaks into a status message; it is honoured after the last word.
    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            S_RUN: begin
                if (pend_q) begin
                    state_d = S_END;
                end else if (wr && sel_stat && !stat_last_i) begin
                    state_d = S_STAT;
                end else if (pend_d) begin
                    state_d = S_END;
                end
            end
            S_STAT: begin
                if (wr && stat_last_i) begin
                    state_d = pend_d ? S_END : S_RUN;
                end
            end
            S_END: begin
                if (if_ready_i) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_RUN;
            fd_q    <= '0;
        end else begin
            state_q <= state_d;
            fd_q    <= fd_d;
        end
    end

    // Strobes are forced low the instant reset asserts, not at the next edge.
    assign wr_out     = wr && reset_n_i;
    assign slwr_o     = wr_out;
    assign cap_ack_o  = wr_out && sel_cap;
    assign stat_ack_o = wr_out && sel_stat;
    assign fd_o       = wr_out ? sel_data : fd_q;
    assign pktend_o   = clr;
    assign busy_o     = (state_q != S_RUN) || pend_q;

endmodule

`default_nettype wire
